// File: rtl/aixh_mxc_left_qtile_ocollect.sv
// Output collector behind the left tile cell: buffers non-stallable result words and
// writes them to the output buffer at sequential addresses, one job per start pulse.
module aixh_mxc_left_qtile_ocollect #(
    parameter int unsigned DWIDTH     = 64,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned AWIDTH     = 16,
    parameter int unsigned CWIDTH     = 16
) (
    input  logic                          aixh_core_clk2x,
    input  logic                          aixh_core_rst,
    input  logic                          i_start,
    input  logic [AWIDTH-1:0]             i_base_addr,
    input  logic [CWIDTH-1:0]             i_word_count,
    input  logic                          i_lqc_vld,
    input  logic [DWIDTH-1:0]             i_lqc_dat,
    output logic                          o_mem_vld,
    output logic [AWIDTH-1:0]             o_mem_addr,
    output logic [DWIDTH-1:0]             o_mem_dat,
    input  logic                          i_mem_rdy,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [1:0]                    o_err,
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [CWIDTH-1:0]   count_q, count_d;
    logic [CWIDTH-1:0]   rx_cnt_q, rx_cnt_d;
    logic [1:0]          err_q, err_d;
    logic [LW-1:0]       wptr_q, wptr_d;
    logic [LW-1:0]       rptr_q, rptr_d;
    logic                out_vld_q, out_vld_d;
    logic [DWIDTH-1:0]   out_dat_q, out_dat_d;
    logic [DWIDTH-1:0]   mem_q [FIFO_DEPTH];

    logic [LW-1:0] level, level_d;
    logic fifo_empty, fifo_full, hs, out_free, in_job;
    logic push_req, stray, pop, bypass, fifo_wr, drop;

    always_comb begin
        level      = wptr_q - rptr_q;
        fifo_empty = (level == '0);
        fifo_full  = (level == LW'(FIFO_DEPTH));
        hs         = out_vld_q & i_mem_rdy;
        out_free   = ~out_vld_q | hs;
        // rx_cnt never exceeds count, so inequality means words are still expected
        in_job     = (state_q == StRun) && (rx_cnt_q != count_q);
        push_req   = i_lqc_vld & in_job;
        stray      = i_lqc_vld & ~in_job;
        pop        = out_free & ~fifo_empty;
        // Empty FIFO and free output register: skip the FIFO for single-cycle latency
        bypass     = out_free & fifo_empty & push_req;
        fifo_wr    = push_req & ~bypass & (~fifo_full | pop);
        drop       = push_req & ~bypass & fifo_full & ~pop;
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;
        wptr_d    = wptr_q + LW'(fifo_wr);
        rptr_d    = rptr_q + LW'(pop);
        level_d   = wptr_d - rptr_d;
        addr_d    = hs ? addr_q + AWIDTH'(1) : addr_q;
        rx_cnt_d  = push_req ? rx_cnt_q + CWIDTH'(1) : rx_cnt_q;
        err_d     = err_q | {stray, drop};

        if (out_free) begin
            if (pop) begin
                out_vld_d = 1'b1;
                out_dat_d = mem_q[rptr_q[PW-1:0]];
            end else if (bypass) begin
                out_vld_d = 1'b1;
                out_dat_d = i_lqc_dat;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    err_d    = {stray, 1'b0};
                    count_d  = i_word_count;
                    addr_d   = i_base_addr;
                    rx_cnt_d = '0;
                    state_d  = (i_word_count == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                // Look at next-cycle values so o_done follows the last handshake directly
                if ((rx_cnt_d == count_q) && (level_d == '0) && !out_vld_d) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (aixh_core_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            count_q   <= '0;
            rx_cnt_q  <= '0;
            err_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            rx_cnt_q  <= rx_cnt_d;
            err_q     <= err_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (fifo_wr) begin
            mem_q[wptr_q[PW-1:0]] <= i_lqc_dat;
        end
    end

    assign o_mem_vld  = out_vld_q;
    assign o_mem_addr = addr_q;
    assign o_mem_dat  = out_dat_q;
    assign o_busy     = (state_q != StIdle);
    assign o_done     = (state_q == StDone);
    assign o_err      = err_q;
    assign o_level    = level;

endmodule

// File: tb/tb_aixh_mxc_left_qtile_ocollect.sv
// Randomized bench for the left-tile output collector against a queue-based model.
module tb_aixh_mxc_left_qtile_ocollect;

    localparam int DEPTH  = 8;
    localparam int NCYC   = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base = '0;
    logic [15:0] wcount = '0;
    logic        vld = 1'b0;
    logic [63:0] dat = '0;
    logic        rdy = 1'b0;
    logic        mem_vld;
    logic [15:0] mem_addr;
    logic [63:0] mem_dat;
    logic        busy;
    logic        done;
    logic [1:0]  err;
    logic [3:0]  level;

    int total = 0;
    int bad   = 0;

    // Model: q holds every stored word (output register first), capacity DEPTH+1
    int          m_state;
    logic [63:0] q[$];
    int          m_rx, m_cnt, m_nwr;
    logic [15:0] m_base;
    logic [1:0]  m_err;
    int          rdy_pct, vld_pct;
    bit          just_reset;

    aixh_mxc_left_qtile_ocollect dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rst   (rst),
        .i_start         (start),
        .i_base_addr     (base),
        .i_word_count    (wcount),
        .i_lqc_vld       (vld),
        .i_lqc_dat       (dat),
        .o_mem_vld       (mem_vld),
        .o_mem_addr      (mem_addr),
        .o_mem_dat       (mem_dat),
        .i_mem_rdy       (rdy),
        .o_busy          (busy),
        .o_done          (done),
        .o_err           (err),
        .o_level         (level)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        q.delete();
        m_rx = 0; m_cnt = 0; m_nwr = 0;
        m_base = '0;
        m_err = '0;
    endtask

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (q.size() > 0 && rdy) begin
            void'(q.pop_front());
            m_nwr++;
        end
        case (m_state)
            0: begin
                if (vld) m_err[1] = 1'b1;
                if (start) begin
                    m_err   = '0;
                    m_base  = base;
                    m_cnt   = int'(wcount);
                    m_rx    = 0;
                    m_nwr   = 0;
                    m_state = (wcount == 0) ? 2 : 1;
                end
            end
            1: begin
                if (vld) begin
                    if (m_rx < m_cnt) begin
                        m_rx++;
                        if (q.size() < DEPTH + 1) q.push_back(dat);
                        else m_err[0] = 1'b1;
                    end else begin
                        m_err[1] = 1'b1;
                    end
                end
                if (m_rx == m_cnt && q.size() == 0) m_state = 2;
            end
            default: begin
                if (vld) m_err[1] = 1'b1;
                m_state = 0;
            end
        endcase
    endtask

    task automatic compare_outputs();
        logic [15:0] exp_addr;
        int          exp_level;
        exp_addr  = 16'(int'(m_base) + m_nwr);
        exp_level = (q.size() > 0) ? q.size() - 1 : 0;
        check_eq("mem_vld", 64'(mem_vld), 64'(q.size() > 0));
        if (q.size() > 0) begin
            check_eq("mem_addr", 64'(mem_addr), 64'(exp_addr));
            check_eq("mem_dat", mem_dat, q[0]);
        end
        if (just_reset) begin
            check_eq("rst_addr", 64'(mem_addr), 64'd0);
            check_eq("rst_dat", mem_dat, 64'd0);
        end
        check_eq("busy", 64'(busy), 64'(m_state != 0));
        check_eq("done", 64'(done), 64'(m_state == 2));
        check_eq("err", 64'(err), 64'(m_err));
        check_eq("level", 64'(level), 64'(exp_level));
    endtask

    task automatic pick_inputs(input int cyc);
        int r;
        if (cyc % 32 == 0) begin
            r = $urandom_range(4);
            rdy_pct = (r < 2) ? 0 : (r == 2) ? 30 : (r == 3) ? 70 : 100;
            r = $urandom_range(2);
            vld_pct = (r == 0) ? 100 : (r == 1) ? 60 : 25;
        end
        rst   = ($urandom_range(999) == 0);
        start = ($urandom_range(99) < ((m_state == 0) ? 10 : 2));
        r = $urandom_range(9);
        wcount = (r == 0) ? 16'd0 : 16'($urandom_range(14, 1));
        base = $urandom_range(1) ? 16'(16'hFFF8 + $urandom_range(7)) : 16'($urandom);
        dat  = {$urandom, $urandom};
        if (start) vld = 1'b0;
        else if (m_state == 1) vld = ($urandom_range(99) < vld_pct);
        else vld = ($urandom_range(99) < 3);
        rdy = ($urandom_range(99) < rdy_pct);
    endtask

    initial begin
        rdy_pct = 100;
        vld_pct = 100;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        just_reset = 1'b1;
        compare_outputs();
        rst = 1'b0;
        just_reset = 1'b0;
        @(posedge clk);
        model_step();
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            compare_outputs();
            just_reset = 1'b0;
            pick_inputs(cyc);
            @(posedge clk);
            model_step();
            if (rst) just_reset = 1'b1;
        end
        @(negedge clk);
        compare_outputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
